// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine.
// A CPU write to REG_ADDR latches a source page and copies XFER_LEN bytes
// from {page, 8'h00} upward into OAM indices 0..XFER_LEN-1, spending one
// READ cycle and one WRITE cycle per byte.
// Optional feature: define OAM_DMA_LOCKOUT_EN to assert cpu_oam_block while
// a transfer runs and the CPU addresses the OAM window; otherwise it is 0.
module oam_dma #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       XFER_LEN = 160,
  parameter logic [ADDR_W-1:0] REG_ADDR = 16'hFF46,
  parameter logic [ADDR_W-1:0] OAM_BASE = 16'hFE00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_re,
  input  logic [DATA_W-1:0] src_rdata,
  output logic [7:0]        oam_addr,
  output logic [DATA_W-1:0] oam_wdata,
  output logic              oam_we,
  output logic              busy,
  output logic              cpu_oam_block
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(XFER_LEN - 1);
  localparam int unsigned OAM_END  = 32'(OAM_BASE) + XFER_LEN;

`ifdef OAM_DMA_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  state_t            state;
  logic [7:0]        idx;
  logic [DATA_W-1:0] src_page;
  logic              wr_q;
  logic              trigger;
  logic              last;
  logic              in_oam_win;

  assign trigger = cpu_we && (cpu_addr == REG_ADDR);
  assign last    = (idx == LAST_IDX);

  // Source address is page base plus index, wrapping within ADDR_W bits.
  assign src_addr = ADDR_W'({src_page, 8'h00}) + ADDR_W'(idx);
  assign oam_addr = idx;

  // NOTE: the write strobe is gated combinationally by a same-cycle trigger,
  // because a restart must cancel the byte being written in this very cycle;
  // a registered strobe would already be committed.
  assign oam_we    = wr_q && !trigger;
  assign oam_wdata = wr_q ? src_rdata : '0;

  // Transfer FSM: state, index, latched page and registered strobes.
  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the pre-edge values of each other, as real flops do.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      src_page <= '0;
      src_re   <= 1'b0;
      wr_q     <= 1'b0;
      busy     <= 1'b0;
    end else if (trigger) begin
      state    <= S_READ;
      idx      <= '0;
      src_page <= cpu_wdata;
      src_re   <= 1'b1;
      wr_q     <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        S_READ: begin
          state  <= S_WRITE;
          src_re <= 1'b0;
          wr_q   <= 1'b1;
          busy   <= 1'b1;
        end
        S_WRITE: begin
          state  <= last ? S_IDLE : S_READ;
          idx    <= idx + 8'd1;
          src_re <= !last;
          wr_q   <= 1'b0;
          busy   <= !last;
        end
        default: begin
          state  <= S_IDLE;
          src_re <= 1'b0;
          wr_q   <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Register readback: returns the latched page one cycle after the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata <= '0;
    end else if (cpu_re && (cpu_addr == REG_ADDR)) begin
      cpu_rdata <= src_page;
    end
  end

  // OAM window decode used for the optional CPU lockout.
  assign in_oam_win    = (cpu_addr >= OAM_BASE) && (32'(cpu_addr) < OAM_END);
  assign cpu_oam_block = LOCKOUT_EN && busy && in_oam_win;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma. A 160-byte instance is the main
// target; a 256-byte instance shares the CPU bus for the full-page case.
// Each instance has its own source memory returning data one cycle after
// src_re, with contents given by a fixed address hash.
module tb_oam_dma;

`ifdef OAM_DMA_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;

  logic [7:0]  cpu_rdata, cpu_rdata2;
  logic [15:0] src_addr, src_addr2;
  logic        src_re, src_re2;
  logic [7:0]  src_rdata = 8'h00;
  logic [7:0]  src_rdata2 = 8'h00;
  logic [7:0]  oam_addr, oam_addr2;
  logic [7:0]  oam_wdata, oam_wdata2;
  logic        oam_we, oam_we2;
  logic        busy, busy2;
  logic        blk, blk2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata),
    .src_addr(src_addr), .src_re(src_re), .src_rdata(src_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .busy(busy), .cpu_oam_block(blk)
  );

  oam_dma #(.XFER_LEN(256)) dut256 (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata2),
    .src_addr(src_addr2), .src_re(src_re2), .src_rdata(src_rdata2),
    .oam_addr(oam_addr2), .oam_wdata(oam_wdata2), .oam_we(oam_we2),
    .busy(busy2), .cpu_oam_block(blk2)
  );

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // Source memories: synchronous read, data valid the cycle after src_re.
  always @(posedge clk) begin
    if (src_re)  src_rdata  <= mem_f(src_addr);
    if (src_re2) src_rdata2 <= mem_f(src_addr2);
  end

  // Monitor view selects which instance observe() watches.
  logic        sel256 = 1'b0;
  logic        mon_re, mon_we, mon_busy;
  logic [15:0] mon_saddr;
  logic [7:0]  mon_oaddr, mon_odata;
  assign mon_re    = sel256 ? src_re2    : src_re;
  assign mon_we    = sel256 ? oam_we2    : oam_we;
  assign mon_busy  = sel256 ? busy2      : busy;
  assign mon_saddr = sel256 ? src_addr2  : src_addr;
  assign mon_oaddr = sel256 ? oam_addr2  : oam_addr;
  assign mon_odata = sel256 ? oam_wdata2 : oam_wdata;

  int          m_rd, m_wr, m_busy, m_bad;
  logic [15:0] m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sample now, then advance one cycle; repeat n times. Reads must walk
  // base+0, base+1, ...; writes must hit OAM 0, 1, ... with that byte's data.
  task automatic observe(input int n, input logic [15:0] base);
    m_rd = 0; m_wr = 0; m_busy = 0; m_bad = 0; m_last = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (mon_re && mon_we) m_bad++;
      if (mon_re) begin
        if (mon_saddr !== base + 16'(m_rd)) m_bad++;
        m_last = mon_saddr;
        m_rd++;
      end
      if (mon_we) begin
        if (mon_oaddr !== 8'(m_wr) || mon_odata !== mem_f(base + 16'(m_wr))) m_bad++;
        m_wr++;
      end
      if (mon_busy) m_busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_addr = a; cpu_re = 1'b1;
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_addr = 16'h0000;
  endtask

  initial begin
    reset_n = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_busy", busy, 0);
    check("rst_src_re", src_re, 0);
    check("rst_oam_we", oam_we, 0);
    check("rst_src_addr", src_addr, 0);
    check("rst_oam_addr", oam_addr, 0);
    check("rst_oam_wdata", oam_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_block", blk, 0);
    check("rst_busy256", busy2, 0);
    check("rst_rdata256", cpu_rdata2, 0);
    check("rst_block256", blk2, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full 160-byte copy from page C0
    cpu_write(16'hFF46, 8'hC0);
    observe(330, 16'hC000);
    check("full_reads", m_rd, 160);
    check("full_writes", m_wr, 160);
    check("full_busy_cycles", m_busy, 320);
    check("full_errors", m_bad, 0);
    check("full_last_src", m_last, 16'hC09F);

    // Restart with page D0 while reading byte 50
    cpu_write(16'hFF46, 8'hC0);
    observe(100, 16'hC000);
    check("pre_restart_writes", m_wr, 50);
    check("at50_src_re", src_re, 1);
    check("at50_src_addr", src_addr, 16'hC032);
    check("at50_busy", busy, 1);
    cpu_write(16'hFF46, 8'hD0);
    observe(330, 16'hD000);
    check("restart_reads", m_rd, 160);
    check("restart_writes", m_wr, 160);
    check("restart_busy_cycles", m_busy, 320);
    check("restart_errors", m_bad, 0);

    // Trigger coinciding with the final write cancels it
    cpu_write(16'hFF46, 8'hC0);
    observe(319, 16'hC000);
    check("prefinal_writes", m_wr, 159);
    check("final_oam_we", oam_we, 1);
    check("final_oam_addr", oam_addr, 8'd159);
    cpu_addr = 16'hFF46; cpu_wdata = 8'h40; cpu_we = 1'b1;
    #1;
    check("final_suppressed", oam_we, 0);
    check("final_busy", busy, 1);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    observe(330, 16'h4000);
    check("final_restart_writes", m_wr, 160);
    check("final_restart_busy", m_busy, 320);
    check("final_restart_errors", m_bad, 0);

    // 256-byte copy from page FF, address top at FFFF
    sel256 = 1'b1;
    cpu_write(16'hFF46, 8'hFF);
    observe(520, 16'hFF00);
    check("p256_reads", m_rd, 256);
    check("p256_writes", m_wr, 256);
    check("p256_busy_cycles", m_busy, 512);
    check("p256_errors", m_bad, 0);
    check("p256_last_src", m_last, 16'hFFFF);
    sel256 = 1'b0;

    // Reset mid-transfer at byte 80
    cpu_write(16'hFF46, 8'hC0);
    observe(160, 16'hC000);
    check("pre_reset_writes", m_wr, 80);
    check("pre_reset_src_re", src_re, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_src_re", src_re, 0);
    check("mid_rst_oam_we", oam_we, 0);
    check("mid_rst_oam_addr", oam_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    observe(50, 16'hC000);
    check("post_rst_writes", m_wr, 0);
    check("post_rst_reads", m_rd, 0);
    check("post_rst_busy", m_busy, 0);

    // Register readback
    cpu_write(16'hFF46, 8'h12);
    check("rdata_before_read", cpu_rdata, 8'h00);
    cpu_read(16'hFF46);
    check("rdata_12", cpu_rdata, 8'h12);
    cpu_write(16'hFF46, 8'h34);
    check("rdata_hold_on_write", cpu_rdata, 8'h12);
    cpu_read(16'hFF47);
    check("rdata_other_addr", cpu_rdata, 8'h12);
    cpu_read(16'hFF46);
    check("rdata_34", cpu_rdata, 8'h34);

    // OAM lockout window during the page-34 transfer
    check("lock_busy", busy, 1);
    cpu_addr = 16'hFE10; #1;
    check("block_fe10", blk, 32'(LOCK));
    cpu_addr = 16'hFE9F; #1;
    check("block_fe9f", blk, 32'(LOCK));
    cpu_addr = 16'hFEA0; #1;
    check("block_fea0", blk, 0);
    cpu_addr = 16'hFDFF; #1;
    check("block_fdff", blk, 0);
    cpu_addr = 16'h0000;
    repeat (330) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    cpu_addr = 16'hFE10; #1;
    check("block_idle", blk, 0);
    cpu_addr = 16'h0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DATA_W, 8, data width of the CPU, source and OAM buses.
REQ-002 Parameter ADDR_W, 16, CPU and source address width.
REQ-003 Parameter XFER_LEN, 160, bytes per transfer; legal range 1..256.
REQ-004 Parameter REG_ADDR, 16'hFF46, CPU address of the DMA trigger register.
REQ-005 Parameter OAM_BASE, 16'hFE00, first CPU address of the OAM window.
REQ-006 Port clk, in, 1, the only clock; all state changes on its rising edge.
REQ-007 Port reset_n, in, 1, asynchronous active-low reset.
REQ-008 Port cpu_addr, in, ADDR_W, CPU bus address.
REQ-009 Port cpu_wdata, in, DATA_W, CPU write data.
REQ-010 Port cpu_we, in, 1, CPU write strobe, one cycle per access.
REQ-011 Port cpu_re, in, 1, CPU read strobe, one cycle per access.
REQ-012 Port cpu_rdata, out, DATA_W, register readback data.
REQ-013 Port src_addr, out, ADDR_W, source memory read address.
REQ-014 Port src_re, out, 1, source read strobe.
REQ-015 Port src_rdata, in, DATA_W, source data, valid the cycle after src_re.
REQ-016 Port oam_addr, out, 8, OAM write index.
REQ-017 Port oam_wdata, out, DATA_W, OAM write data.
REQ-018 Port oam_we, out, 1, OAM write strobe.
REQ-019 Port busy, out, 1, transfer in progress.
REQ-020 Port cpu_oam_block, out, 1, CPU access to the OAM window must be suppressed.

Function
REQ-021 A trigger SHALL be cpu_we high with cpu_addr == REG_ADDR. On a trigger, src_page SHALL latch cpu_wdata, idx SHALL clear to 0, and the FSM SHALL enter READ on the next edge.
REQ-022 The FSM SHALL have states IDLE, READ and WRITE, with transitions IDLE->READ on a trigger, READ->WRITE always, WRITE->READ while idx != XFER_LEN-1, and WRITE->IDLE when idx == XFER_LEN-1.
REQ-023 In READ, src_re SHALL be 1 and src_addr SHALL equal {src_page, 8'h00} + idx.
REQ-024 In WRITE, oam_we SHALL be 1, oam_addr SHALL equal idx, oam_wdata SHALL equal src_rdata, and idx SHALL increment.
REQ-025 src_re and oam_we SHALL be 0 in every other state, and the two strobes SHALL never be high together.
REQ-026 busy SHALL be 1 in READ and WRITE and 0 in IDLE, so a transfer lasts exactly 2*XFER_LEN cycles after the trigger edge.
REQ-027 A trigger during READ or WRITE SHALL abort the current transfer without completing its pending write, reload src_page, clear idx, and enter READ on the next edge.
REQ-028 If a CPU write to REG_ADDR coincides with the final WRITE cycle, that final write SHALL be suppressed and the restart SHALL take priority.
REQ-029 A cpu_re with cpu_addr == REG_ADDR SHALL place src_page on cpu_rdata on the following cycle; otherwise cpu_rdata SHALL hold its previous value.
REQ-030 src_addr arithmetic SHALL be ADDR_W wide and wrap modulo 2^ADDR_W.

Reset
REQ-031 While reset_n is low, the FSM SHALL be IDLE, and idx, src_page, cpu_rdata, src_addr, oam_addr and oam_wdata SHALL be 0.
REQ-032 While reset_n is low, src_re, oam_we, busy and cpu_oam_block SHALL be 0.
REQ-033 A reset asserted mid-transfer SHALL abort the transfer immediately, and no further OAM write SHALL occur.

Configuration
REQ-034 With OAM_DMA_LOCKOUT_EN defined, cpu_oam_block SHALL equal busy AND (OAM_BASE <= cpu_addr < OAM_BASE+XFER_LEN).
REQ-035 With OAM_DMA_LOCKOUT_EN not defined, cpu_oam_block SHALL be tied to 0.

Verification
REQ-036 The bench SHALL write 8'hC0 to 16'hFF46 -> 160 READ/WRITE pairs, src_addr 16'hC000..16'hC09F, oam_addr 0..159 matching the source data, busy high for exactly 320 cycles.
REQ-037 The bench SHALL write 8'hC0, then write 8'hD0 at idx 50 -> idx restarts at 0, src_addr 16'hD000 upward, busy stays high, and a full 160 bytes are copied from 16'hD000.
REQ-038 The bench SHALL write 8'hFF with XFER_LEN=256 -> src_addr runs 16'hFF00..16'hFFFF with no wrap error.
REQ-039 The bench SHALL assert reset_n low at idx 80 -> busy, src_re and oam_we are 0 in the same cycle, and no writes occur after release until a new trigger.
REQ-040 The bench SHALL write 8'h12 then read 16'hFF46 -> cpu_rdata == 8'h12 on the next cycle.
REQ-041 With OAM_DMA_LOCKOUT_EN defined, the bench SHALL drive cpu_addr 16'hFE10 during a transfer -> cpu_oam_block = 1, and cpu_addr 16'hFEA0 -> 0; with the macro not defined, cpu_oam_block is always 0.
